async_fifo_wr_arb: RTL

Round-robin write-port arbiter that shares one `async_fifo` write port among `NumReq` requesters in the write clock domain. Each requester presents a valid/ready stream. The arbiter grants one requester at a time and forwards its data to the FIFO only while the FIFO is not full. Beats are never dropped or duplicated. Sustained throughput is one beat per cycle.

---
 rtl/async_fifo_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 30 +++
 rtl/async_fifo_wr_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/async_fifo_arb_pkg.sv
// Shared types and helpers for the async FIFO write-port arbiter.
package async_fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int grant_w(input int num_req);
    int w;
    w = $clog2(num_req);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request after i_last_id, wrapping, i_last_id itself last.
module rr_pick
  import async_fifo_arb_pkg::*;
#(
  parameter int NumReq = 4,
  localparam int GrantW = grant_w(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [GrantW-1:0] i_last_id,
  output logic              o_any,
  output logic [GrantW-1:0] o_id
);

  // Scan slots last_id+1 .. last_id+NumReq modulo NumReq and keep the first hit.
  always_comb begin
    int unsigned idx_s;
    logic        hit_s;
    idx_s = 32'd0;
    hit_s = 1'b0;
    o_any = 1'b0;
    o_id  = {GrantW{1'b0}};
    for (int k = 1; k <= NumReq; k++) begin
      idx_s = (32'(i_last_id) + 32'(k)) % 32'(NumReq);
      hit_s = ~o_any & i_req[idx_s];
      o_id  = hit_s ? idx_s[GrantW-1:0] : o_id;
      o_any = o_any | hit_s;
    end
  end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Round-robin arbiter sharing one async_fifo write port among NumReq valid/ready requesters.
// Define ASYNC_FIFO_ARB_BURST_EN to let a grant carry up to MaxBurst beats (ended early by i_req_last).
module async_fifo_wr_arb
  import async_fifo_arb_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int Width    = 8,
  parameter int MaxBurst = 4,
  localparam int GrantW  = grant_w(NumReq)
) (
  input  logic                          clk_wr,
  input  logic                          rst_n,
  input  logic [NumReq-1:0]             i_req_valid,
  input  logic [NumReq-1:0][Width-1:0]  i_req_data,
  input  logic [NumReq-1:0]             i_req_last,
  output logic [NumReq-1:0]             o_req_ready,
  input  logic                          i_wr_full,
  output logic                          o_wr_en,
  output logic [Width-1:0]              o_wr_data,
  output logic                          o_grant_valid,
  output logic [GrantW-1:0]             o_grant_id
);

  localparam int CntW = grant_w(MaxBurst);
  localparam logic [GrantW-1:0] LastIdRst = GrantW'(NumReq - 1);

  arb_state_e        state_r, state_s;
  logic [GrantW-1:0] grant_id_r, grant_id_s;
  logic [GrantW-1:0] last_id_r, last_id_s;
  logic [GrantW-1:0] pick_last_s, pick_id_s;
  logic              pick_any_s;
  logic              busy_s, xfer_s, hold_s, mid_burst_s;
  logic [CntW-1:0]   beat_cnt_r;

  assign busy_s = (state_r == BUSY);
  assign xfer_s = busy_s & ~i_wr_full & i_req_valid[grant_id_r];
  // While busy the only re-pick happens on a releasing transfer, where the current grant becomes last.
  assign pick_last_s = busy_s ? grant_id_r : last_id_r;

  rr_pick #(.NumReq(NumReq)) u_pick (
    .i_req     (i_req_valid),
    .i_last_id (pick_last_s),
    .o_any     (pick_any_s),
    .o_id      (pick_id_s)
  );

`ifdef ASYNC_FIFO_ARB_BURST_EN
  logic [CntW-1:0] beat_cnt_s;

  assign hold_s = ~i_req_last[grant_id_r] & (beat_cnt_r < CntW'(MaxBurst - 1));

  // Beats already taken in the current grant; cleared whenever the grant rotates.
  always_comb begin
    beat_cnt_s = beat_cnt_r;
    if (xfer_s) begin
      if (hold_s) begin
        beat_cnt_s = beat_cnt_r + CntW'(1);
      end else begin
        beat_cnt_s = {CntW{1'b0}};
      end
    end else begin
      beat_cnt_s = beat_cnt_r;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= {CntW{1'b0}};
    end else begin
      beat_cnt_r <= beat_cnt_s;
    end
  end
`else
  logic unused_last_s;

  assign unused_last_s = ^i_req_last;
  assign hold_s        = 1'b0;
  assign beat_cnt_r    = {CntW{1'b0}};
`endif

  assign mid_burst_s = (beat_cnt_r != {CntW{1'b0}});

  // Next-state: grant on any request from IDLE, rotate or release on transfer, hold while full.
  always_comb begin
    state_s    = state_r;
    grant_id_s = grant_id_r;
    last_id_s  = last_id_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          grant_id_s = pick_id_s;
          state_s    = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (xfer_s) begin
          if (hold_s) begin
            state_s = BUSY;
          end else begin
            last_id_s = grant_id_r;
            if (pick_any_s) begin
              grant_id_s = pick_id_s;
            end else begin
              state_s = IDLE;
            end
          end
        end else if (i_wr_full || mid_burst_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant_id_r <= {GrantW{1'b0}};
      last_id_r  <= LastIdRst;
    end else begin
      state_r    <= state_s;
      grant_id_r <= grant_id_s;
      last_id_r  <= last_id_s;
    end
  end

  // Ready goes only to the granted requester while the FIFO has room.
  always_comb begin
    o_req_ready = {NumReq{1'b0}};
    for (int g = 0; g < NumReq; g++) begin
      o_req_ready[g] = busy_s & (grant_id_r == GrantW'(g)) & ~i_wr_full;
    end
  end

  assign o_wr_en       = xfer_s;
  assign o_wr_data     = busy_s ? i_req_data[grant_id_r] : {Width{1'b0}};
  assign o_grant_valid = busy_s;
  assign o_grant_id    = grant_id_r;

endmodule
